fir_seq_ctrl: RTL and testbench
===============================

# fir_seq_ctrl

Sequencer for the shift-register FIR filter core. Accepts one frame of SIGNAL_LEN input samples on a valid/ready stream, clears the core, loads the samples through the core's load operation, runs the convolution until the core reports done, then streams the SIGNAL_LEN results out on a second valid/ready stream. It sits between the sample source/sink and a single filter instance, which is instantiated at the parent level.

## Interface
- SIGNAL_LEN, 1000: samples per frame; must match the filter's signal length.
- COEF_LEN, 100: filter taps; must match the filter's coefficient length.
- TIMEOUT, SIGNAL_LEN*(COEF_LEN+1)+8: maximum number of COMPUTE cycles before an error is raised.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle frame request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky compute-timeout flag; cleared by the next accepted start.
- in_valid  in  1, in_ready  out  1, in_data  in  32: input sample stream.
- out_valid  out  1, out_ready  in  1, out_data  out  32, out_last  out  1: result stream.
- fir_reset  out  1: synchronous clear to the filter core.
- fir_op  out  2: 00 idle, 01 load, 10 run, 11 read.
- fir_addr  out  32, fir_x  out  32: filter address and load data.
- fir_y  in  32, fir_done  in  1: filter read data and done flag.

## Operation
- States: IDLE, CLEAR, LOAD, COMPUTE, READ_REQ, READ_OUT.
- IDLE: all filter controls are 0. start → CLEAR and err is cleared. start in any other state is ignored.
- CLEAR (1 cycle): fir_reset=1, fir_op=00 (the core's clear does not mask op, so op must be 00). Counter k is set to 0. Next state is LOAD.
- LOAD: in_ready=1.
  - On in_valid&&in_ready: fir_op=01, fir_addr=k, fir_x=in_data, k++.
  - Otherwise fir_op=00.
  - On accepting the sample with k==SIGNAL_LEN-1: go to COMPUTE, k=0, cycle counter=0.
- COMPUTE: fir_op=10 every cycle and the cycle counter increments.
  - fir_done==1 → READ_REQ.
  - Counter reaches TIMEOUT with fir_done still 0 → err=1, go to IDLE.
- READ_REQ (1 cycle): fir_op=11, fir_addr=k. Next state is READ_OUT.
- READ_OUT: fir_op=00. out_data is wired to fir_y, which holds because op≠11. out_valid=1. out_last=(k==SIGNAL_LEN-1).
  - On out_ready: if last → IDLE, else k++ and → READ_REQ.
- out_data/out_last/out_valid are stable while out_valid && !out_ready.
- fir_addr and fir_x are 0 whenever the current state does not use them.
- Counters are 32-bit unsigned. k never exceeds SIGNAL_LEN-1.
- Asynchronous reset mid-frame returns to IDLE immediately. The core keeps stale state; the next frame's CLEAR removes it.

## Timing
- Reset values:
  - state=IDLE, busy=0, err=0, in_ready=0, out_valid=0, out_last=0.
  - fir_reset=0, fir_op=00, fir_addr=0, fir_x=0, k=0.
  - out_data follows fir_y.
- Outputs derived from registered state. Combinational only from the handshake inputs: fir_op/fir_addr/fir_x in LOAD depend on in_valid.
- start at cycle t: CLEAR in t+1, LOAD from t+2. One sample is accepted per cycle at full rate.
- COMPUTE lasts SIGNAL_LEN*(COEF_LEN+1)+1 cycles until fir_done is seen.
- Readout is at best 1 result per 2 cycles. out_valid is high the cycle after READ_REQ.
- The frame ends on the last out handshake; busy falls in the following cycle.

## Structure
- Shared package fir_pkg holds:
  - the fir_op_t enum (FIR_OP_IDLE=2'b00, FIR_OP_LOAD=2'b01, FIR_OP_RUN=2'b10, FIR_OP_READ=2'b11);
  - the fir_seq_state_t enum;
  - the default SIGNAL_LEN/COEF_LEN constants.
- No sub-module. The single FSM with counters k and cycle is the whole block. The filter core is instantiated beside it in the parent.

## Test plan
- All scenarios use SIGNAL_LEN=4, COEF_LEN=3, all coefficients 1, with the filter attached.
- Nominal frame: start, inputs 1,2,3,4 at full rate → outputs 1,3,6,9 in order, out_last only on 9; fir_reset high exactly one cycle; COMPUTE lasts 17 cycles.
- Input gaps: in_valid toggling every other cycle with 5,0,7,2 → fir_op=01 only on handshake cycles, addresses 0..3, outputs 5,5,12,9.
- Output backpressure: out_ready low for 3 cycles on each result → out_data/out_last stable while stalled; result sequence unchanged.
- Ignored start and back-to-back frames: start pulsed during LOAD has no effect; a second frame 0,0,0,1 right after the first → outputs 0,0,0,1 with no residue from the first frame.
- Timeout and async reset:
  - Bench forces fir_done=0 → err=1 after TIMEOUT (=24) COMPUTE cycles and state returns to IDLE; the next start clears err.
  - reset asserted mid-LOAD → all outputs at their reset values immediately; a subsequent frame is correct.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR core and its sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    FIR_OP_IDLE = 2'b00,
    FIR_OP_LOAD = 2'b01,
    FIR_OP_RUN  = 2'b10,
    FIR_OP_READ = 2'b11
  } fir_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_READ_REQ,
    S_READ_OUT
  } fir_seq_state_t;

  localparam int unsigned FIR_SIGNAL_LEN = 1000;
  localparam int unsigned FIR_COEF_LEN   = 100;

endpackage

// File: rtl/fir_seq_ctrl.sv
// Frame sequencer for the shift-register FIR core: clear, load, run, read out.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned SIGNAL_LEN = FIR_SIGNAL_LEN,
  parameter int unsigned COEF_LEN   = FIR_COEF_LEN,
  parameter int unsigned TIMEOUT    = SIGNAL_LEN * (COEF_LEN + 1) + 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        fir_reset,
  output logic [1:0]  fir_op,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x,
  input  logic [31:0] fir_y,
  input  logic        fir_done
);

  localparam logic [31:0] K_LAST  = 32'(SIGNAL_LEN - 1);
  localparam logic [31:0] CYC_MAX = 32'(TIMEOUT);

  fir_seq_state_t state_q, state_d;
  logic [31:0]    k_q, k_d;
  logic [31:0]    cyc_q, cyc_d;
  logic           err_q, err_d;
  fir_op_t        op_d;

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign out_data = fir_y;
  assign fir_op   = op_d;

  // State, counters and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  // Next-state and filter/stream controls; LOAD controls follow in_valid directly.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cyc_d     = cyc_q;
    err_d     = err_q;
    op_d      = FIR_OP_IDLE;
    fir_addr  = '0;
    fir_x     = '0;
    fir_reset = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fir_reset = 1'b1;
        k_d       = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d     = FIR_OP_LOAD;
          fir_addr = k_q;
          fir_x    = in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            cyc_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            k_d = k_q + 32'd1;
          end
        end
      end
      S_COMPUTE: begin
        op_d  = FIR_OP_RUN;
        cyc_d = cyc_q + 32'd1;
        if (fir_done) begin
          state_d = S_READ_REQ;
        end else if (cyc_q + 32'd1 == CYC_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ_REQ: begin
        op_d     = FIR_OP_READ;
        fir_addr = k_q;
        state_d  = S_READ_OUT;
      end
      S_READ_OUT: begin
        // fir_y holds its value here because op is not READ
        out_valid = 1'b1;
        out_last  = (k_q == K_LAST);
        if (out_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_IDLE;
          end else begin
            k_d     = k_q + 32'd1;
            state_d = S_READ_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl with a behavioural FIR core (4 samples, 3 unit taps).
module tb_fir_seq_ctrl;

  localparam int SL  = 4;
  localparam int CL  = 3;
  localparam int TMO = SL * (CL + 1) + 8;
  localparam int RUN_CYCLES = SL * (CL + 1) + 1;

  typedef logic [31:0] frame_t [SL];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, err;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        fir_reset;
  logic [1:0]  fir_op;
  logic [31:0] fir_addr, fir_x, fir_y;
  logic        fir_done;

  int n_checks = 0;
  int n_err    = 0;
  int rcount;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.SIGNAL_LEN(SL), .COEF_LEN(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fir_reset(fir_reset), .fir_op(fir_op), .fir_addr(fir_addr), .fir_x(fir_x),
    .fir_y(fir_y), .fir_done(fir_done)
  );

  // Behavioural filter core: load memory, run counter, done after SL*(CL+1) run cycles.
  logic [31:0] fx [SL];
  logic [31:0] fy [SL];
  int          frun;
  logic        fdone_q = 1'b0;
  logic        force_notdone = 1'b0;

  assign fir_done = fdone_q && !force_notdone;

  function automatic logic [31:0] core_y(input int n);
    logic [31:0] acc = '0;
    for (int j = 0; j < CL; j++)
      if (n - j >= 0) acc = acc + fx[n - j];
    return acc;
  endfunction

  always @(posedge clk) begin
    if (fir_reset) begin
      for (int i = 0; i < SL; i++) begin
        fx[i] <= '0;
        fy[i] <= '0;
      end
      frun    <= 0;
      fdone_q <= 1'b0;
    end else begin
      case (fir_op)
        2'b01: fx[fir_addr[1:0]] <= fir_x;
        2'b10: begin
          frun <= frun + 1;
          if (frun == SL * (CL + 1) - 1) begin
            fdone_q <= 1'b1;
            for (int i = 0; i < SL; i++) fy[i] <= core_y(i);
          end
        end
        2'b11: fir_y <= fy[fir_addr[1:0]];
        default: ;
      endcase
    end
  end

  // Expected results: y[n] = sum of the last CL inputs (unit taps, zero history).
  function automatic void ref_frame(input frame_t x, output frame_t y);
    for (int n = 0; n < SL; n++) begin
      y[n] = '0;
      for (int j = 0; j < CL; j++)
        if (n - j >= 0) y[n] = y[n] + x[n - j];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_fir_reset"}, fir_reset, 0);
    chk({tag, "_fir_op"}, fir_op, 0);
    chk({tag, "_fir_addr"}, fir_addr, 0);
    chk({tag, "_fir_x"}, fir_x, 0);
    chk({tag, "_out_data"}, out_data, fir_y);
  endtask

  task automatic sample();
    @(negedge clk);
    if (fir_reset) rcount++;
  endtask

  // gap: 0 full rate, 1 idle cycle before every sample, 2 random idle cycles.
  // stall: cycles of out_ready low per result, -1 for random.
  task automatic run_frame(input frame_t d, input int gap, input int stall,
                           input bit poke_start, input bit tmo);
    frame_t e;
    int n, got, srem, cyc;
    bit held, prev_rr;
    logic [31:0] hd;
    logic hl;
    ref_frame(d, e);
    rcount = 0;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    chk("idle_before_start_busy", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    sample();
    chk("clear_busy", busy, 1);
    chk("clear_fir_reset", fir_reset, 1);
    chk("clear_fir_op", fir_op, 0);
    chk("clear_err", err, 0);
    chk("clear_in_ready", in_ready, 0);
    for (int i = 0; i < SL; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1) || (poke_start && i == 1)) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        start    = poke_start && i == 1;
        sample();
        chk("gap_in_ready", in_ready, 1);
        chk("gap_fir_op", fir_op, 0);
        chk("gap_fir_addr", fir_addr, 0);
        chk("gap_fir_x", fir_x, 0);
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = d[i];
      sample();
      chk("load_in_ready", in_ready, 1);
      chk("load_fir_op", fir_op, 1);
      chk("load_fir_addr", fir_addr, i);
      chk("load_fir_x", fir_x, d[i]);
    end
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      sample();
      if (fir_op === 2'b10) n++;
      else break;
    end
    if (tmo) begin
      chk("timeout_compute_cycles", n, TMO);
      chk("timeout_busy", busy, 0);
      chk("timeout_err", err, 1);
      chk("timeout_fir_op", fir_op, 0);
      chk("timeout_fir_reset_count", rcount, 1);
      return;
    end
    chk("compute_cycles", n, RUN_CYCLES);
    chk("first_read_op", fir_op, 3);
    chk("first_read_addr", fir_addr, 0);
    got = 0; held = 0; prev_rr = 1; cyc = 0;
    srem = (stall < 0) ? $urandom_range(0, 3) : stall;
    while (got < SL && cyc < 200) begin
      @(posedge clk); #1 out_ready = (srem == 0);
      sample();
      cyc++;
      if (prev_rr) chk("valid_after_read_req", out_valid, 1);
      if (out_valid) begin
        chk("readout_fir_op", fir_op, 0);
        if (!held) begin
          chk("out_data", out_data, e[got]);
          chk("out_last", out_last, (got == SL - 1));
          hd = out_data;
          hl = out_last;
        end else begin
          chk("stall_out_data", out_data, hd);
          chk("stall_out_last", out_last, hl);
        end
        if (out_ready) begin
          got++;
          held = 0;
          srem = (stall < 0) ? $urandom_range(0, 3) : stall;
        end else begin
          srem--;
          held = 1;
        end
        prev_rr = 0;
      end else begin
        chk("read_req_op", fir_op, 3);
        chk("read_req_addr", fir_addr, got);
        prev_rr = 1;
      end
    end
    chk("readout_count", got, SL);
    @(posedge clk); #1 out_ready = 1'b0;
    sample();
    chk("end_busy", busy, 0);
    chk("end_out_valid", out_valid, 0);
    chk("end_err", err, 0);
    chk("fir_reset_count", rcount, 1);
  endtask

  frame_t fr;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 32'h1234;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    in_valid = 1'b0;
    reset = 1'b0;

    // Nominal frame
    fr = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_frame(fr, 0, 0, 0, 0);

    // Input gaps
    fr = '{32'd5, 32'd0, 32'd7, 32'd2};
    run_frame(fr, 1, 0, 0, 0);

    // Output backpressure
    fr = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_frame(fr, 0, 3, 0, 0);

    // Ignored start during LOAD, then back-to-back frame
    fr = '{32'd9, 32'd8, 32'd7, 32'd6};
    run_frame(fr, 0, 0, 1, 0);
    fr = '{32'd0, 32'd0, 32'd0, 32'd1};
    run_frame(fr, 0, 0, 0, 0);

    // Compute timeout, err sticky in IDLE, then cleared by next start
    force_notdone = 1'b1;
    for (int i = 0; i < SL; i++) fr[i] = $urandom;
    run_frame(fr, 0, 0, 0, 1);
    force_notdone = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky_idle", err, 1);
    fr = '{32'd2, 32'd4, 32'd6, 32'd8};
    run_frame(fr, 0, 0, 0, 0);

    // Asynchronous reset in the middle of LOAD
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 32'd11;
    @(posedge clk); #1 in_data = 32'd12;
    #2 reset = 1'b1;
    #1 chk_reset_vals("midload_reset");
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < SL; i++) fr[i] = $urandom;
    run_frame(fr, 0, 0, 0, 0);

    // Randomized frames with random gaps and stalls
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < SL; i++) fr[i] = $urandom;
      run_frame(fr, 2, -1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
